// File: rtl/reg_load_arbiter.sv
// ---------------------------------------------------------------------------
// reg_load_arbiter
//
// Round-robin arbiter and load sequencer sharing one loadable WIDTH-bit
// register among NREQ requesters. A granted requester's word is latched
// onto REG_DIN, REG_LOAD pulses for one cycle, and a one-cycle ACK returns
// to the winner. Arbitration is done only in IDLE, so REQ changes during a
// transaction are ignored.
//
// Optional feature macro: READBACK_EN
//   defined   : a CHECK state follows LOAD and compares REG_Q with REG_DIN;
//               a mismatch sets the sticky ERR flag (cleared only by reset).
//   undefined : LOAD goes straight to ACK, ERR stays 0, REG_Q is unused.
//
// Ports
//   CLK       in   rising-edge clock
//   RST_N     in   asynchronous active-low reset
//   REQ       in   [NREQ]        request per requester
//   DATA      in   [NREQ*WIDTH]  requester i's word at DATA[WIDTH*i +: WIDTH]
//   GNT       out  [NREQ]        one-hot grant, high during LOAD (and CHECK)
//   ACK       out  [NREQ]        one-hot, one-cycle completion pulse
//   REG_DIN   out  [WIDTH]       shared register DIN, holds last loaded word
//   REG_LOAD  out                shared register LOAD, one cycle per grant
//   REG_Q     in   [WIDTH]       shared register Q, readback only
//   BUSY      out                high whenever the FSM is not in IDLE
//   ERR       out                sticky readback-mismatch flag
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module reg_load_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4   // legal range 2..8
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [NREQ-1:0]         REQ,
    input  logic [NREQ*WIDTH-1:0]   DATA,
    output logic [NREQ-1:0]         GNT,
    output logic [NREQ-1:0]         ACK,
    output logic [WIDTH-1:0]        REG_DIN,
    output logic                    REG_LOAD,
    input  logic [WIDTH-1:0]        REG_Q,
    output logic                    BUSY,
    output logic                    ERR
);

    localparam int IW = $clog2(NREQ);
    typedef logic [IW-1:0] idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    idx_t               last_q,  last_d;     // most recently acknowledged requester
    idx_t               win_q,   win_d;      // requester owning the current transaction
    logic [NREQ-1:0]    gnt_q,   gnt_d;
    logic [NREQ-1:0]    ack_q,   ack_d;
    logic [WIDTH-1:0]   reg_din_q, reg_din_d;
    logic               reg_load_q, reg_load_d;
    logic               busy_q,  busy_d;
    logic               err_q,   err_d;

    // Round-robin pick: scan LAST+1, LAST+2, ... modulo NREQ and take the
    // first requester with REQ set. Scanning up to LAST+NREQ lets the
    // previous winner be chosen again when it is the only one requesting.
    logic pick_found;
    idx_t pick_idx;
    idx_t cand;

    // NOTE: every signal written in an always_comb gets a default at the top,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = idx_t'((int'(last_q) + k) % NREQ);
            if (!pick_found && REQ[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        win_d      = win_q;
        gnt_d      = gnt_q;
        ack_d      = '0;
        reg_din_d  = reg_din_q;     // DIN keeps the last loaded word between transactions
        reg_load_d = 1'b0;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    win_d           = pick_idx;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    reg_din_d       = DATA[WIDTH*int'(pick_idx) +: WIDTH];
                    reg_load_d      = 1'b1;
                    state_d         = ST_LOAD;
                end
            end

            ST_LOAD: begin
`ifdef READBACK_EN
                // Register captures at the end of this cycle; grant stays up
                // through CHECK.
                state_d = ST_CHECK;
`else
                gnt_d        = '0;
                ack_d[win_q] = 1'b1;
                state_d      = ST_ACK;
`endif
            end

`ifdef READBACK_EN
            ST_CHECK: begin
                if (REG_Q != reg_din_q) begin
                    err_d = 1'b1;
                end
                gnt_d        = '0;
                ack_d[win_q] = 1'b1;
                state_d      = ST_ACK;
            end
`endif

            ST_ACK: begin
                last_d  = win_q;
                state_d = ST_IDLE;
            end

            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

`ifndef READBACK_EN
    // Readback is compiled out; REG_Q is intentionally left unobserved.
    logic unused_reg_q;
    assign unused_reg_q = ^REG_Q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            last_q     <= idx_t'(NREQ - 1);   // requester 0 wins first after reset
            win_q      <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            reg_din_q  <= '0;
            reg_load_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            win_q      <= win_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            reg_din_q  <= reg_din_d;
            reg_load_q <= reg_load_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign GNT      = gnt_q;
    assign ACK      = ack_q;
    assign REG_DIN  = reg_din_q;
    assign REG_LOAD = reg_load_q;
    assign BUSY     = busy_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_reg_load_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_load_arbiter
//
// Self-checking bench for reg_load_arbiter (WIDTH=4, NREQ=4). Models the
// shared register, keeps a queue of expected {requester, word} pairs pushed
// as requests are driven, and pops one for every ACK the DUT raises.
// Builds with or without READBACK_EN; latency and ERR expectations follow.
// ---------------------------------------------------------------------------
module tb_reg_load_arbiter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;
    localparam int IW    = $clog2(NREQ);
`ifdef READBACK_EN
    localparam int       LAT      = 3;      // request cycle -> ACK cycle
    localparam logic     EXP_ERR  = 1'b1;   // ERR after a bad readback
`else
    localparam int       LAT      = 2;
    localparam logic     EXP_ERR  = 1'b0;
`endif
    localparam int PERIOD = LAT + 1;        // ACK spacing with REQ held

    logic                  CLK = 1'b0;
    logic                  RST_N;
    logic [NREQ-1:0]       REQ;
    logic [NREQ*WIDTH-1:0] DATA;
    logic [NREQ-1:0]       GNT;
    logic [NREQ-1:0]       ACK;
    logic [WIDTH-1:0]      REG_DIN;
    logic                  REG_LOAD;
    logic [WIDTH-1:0]      REG_Q;
    logic                  BUSY;
    logic                  ERR;

    reg_load_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .REQ      (REQ),
        .DATA     (DATA),
        .GNT      (GNT),
        .ACK      (ACK),
        .REG_DIN  (REG_DIN),
        .REG_LOAD (REG_LOAD),
        .REG_Q    (REG_Q),
        .BUSY     (BUSY),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    // Shared register model; force_bad makes its Q pins read back zero.
    logic [WIDTH-1:0] reg_store = '0;
    logic             force_bad = 1'b0;
    always @(posedge CLK) begin
        if (REG_LOAD === 1'b1) reg_store <= REG_DIN;
    end
    assign REG_Q = force_bad ? '0 : reg_store;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [IW-1:0]    idx;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   ack_cnt = 0;
    int   last_ack_cyc = 0;
    logic err_at_ack = 1'b0;

    // ACK monitor: pops the scoreboard and checks who was acknowledged and
    // what the register holds.
    exp_t            mon_e;
    logic [NREQ-1:0] mon_oh;
    always @(negedge CLK) begin
        if (RST_N === 1'b1 && ACK !== '0) begin
            ack_cnt      = ack_cnt + 1;
            last_ack_cyc = cyc;
            err_at_ack   = ERR;
            n_cmp        = n_cmp + 1;
            if (sb_q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL ack_unexpected: ACK=%b with nothing outstanding (cycle %0d)", ACK, cyc);
            end else begin
                mon_e              = sb_q.pop_front();
                mon_oh             = '0;
                mon_oh[mon_e.idx]  = 1'b1;
                if (ACK !== mon_oh) begin
                    n_err = n_err + 1;
                    $display("FAIL ack_onehot: got %b, expected %b", ACK, mon_oh);
                end
                n_cmp = n_cmp + 1;
                if (reg_store !== mon_e.data) begin
                    n_err = n_err + 1;
                    $display("FAIL reg_value: register holds %h, expected %h", reg_store, mon_e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_data(input int i, input logic [WIDTH-1:0] v);
        DATA[WIDTH*i +: WIDTH] = v;
    endtask

    task automatic push_exp(input int i, input logic [WIDTH-1:0] v);
        exp_t e;
        e.idx  = IW'(i);
        e.data = v;
        sb_q.push_back(e);
    endtask

    task automatic wait_acks(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (ack_cnt < target && n < budget) begin
            tick();
            n++;
        end
        if (ack_cnt < target) begin
            n_cmp = n_cmp + 1;
            n_err = n_err + 1;
            $display("FAIL %s_timeout: acks seen %0d, expected %0d", name, ack_cnt, target);
        end
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    task automatic check_drained(input string name);
        n_cmp = n_cmp + 1;
        if (sb_q.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL %s_drain: %0d expected ACKs outstanding, expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        REQ   = '0;
        DATA  = '0;
        RST_N = 1'b0;
        #12;
        tick();
        RST_N = 1'b1;
        n_cmp = n_cmp + 1;
        if (GNT !== '0)        begin n_err++; $display("FAIL reset_gnt: got %b, expected 0", GNT); end
        n_cmp = n_cmp + 1;
        if (ACK !== '0)        begin n_err++; $display("FAIL reset_ack: got %b, expected 0", ACK); end
        n_cmp = n_cmp + 1;
        if (REG_LOAD !== 1'b0) begin n_err++; $display("FAIL reset_load: got %b, expected 0", REG_LOAD); end
        n_cmp = n_cmp + 1;
        if (REG_DIN !== '0)    begin n_err++; $display("FAIL reset_din: got %h, expected 0", REG_DIN); end
        n_cmp = n_cmp + 1;
        if (BUSY !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b, expected 0", BUSY); end
        n_cmp = n_cmp + 1;
        if (ERR !== 1'b0)      begin n_err++; $display("FAIL reset_err: got %b, expected 0", ERR); end
    endtask

    task automatic test_single();
        int req_cyc;
        int base;
        tick();
        set_data(0, 4'hA);
        REQ     = 4'b0001;
        req_cyc = cyc;
        base    = ack_cnt;
        push_exp(0, 4'hA);
        tick();                                   // LOAD cycle
        REQ = '0;
        n_cmp = n_cmp + 1;
        if (GNT !== 4'b0001)   begin n_err++; $display("FAIL single_gnt: got %b, expected 0001", GNT); end
        n_cmp = n_cmp + 1;
        if (REG_LOAD !== 1'b1) begin n_err++; $display("FAIL single_load: got %b, expected 1", REG_LOAD); end
        n_cmp = n_cmp + 1;
        if (REG_DIN !== 4'hA)  begin n_err++; $display("FAIL single_din: got %h, expected a", REG_DIN); end
        n_cmp = n_cmp + 1;
        if (BUSY !== 1'b1)     begin n_err++; $display("FAIL single_busy: got %b, expected 1", BUSY); end
        tick();
        n_cmp = n_cmp + 1;
        if (REG_LOAD !== 1'b0) begin n_err++; $display("FAIL single_load_pulse: got %b, expected 0", REG_LOAD); end
        wait_acks(base + 1, 10, "single");
        n_cmp = n_cmp + 1;
        if (last_ack_cyc - req_cyc != LAT) begin
            n_err++;
            $display("FAIL single_latency: ACK %0d cycles after request, expected %0d", last_ack_cyc - req_cyc, LAT);
        end
        n_cmp = n_cmp + 1;
        if (GNT !== '0 || BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL single_idle: GNT=%b BUSY=%b, expected 0000/0", GNT, BUSY);
        end
        tick();
        check_drained("single");
    endtask

    task automatic test_round_robin();
        int base;
        int prev;
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_data(i, WIDTH'(i + 1));
        push_exp(0, 4'h1);
        push_exp(1, 4'h2);
        push_exp(2, 4'h3);
        push_exp(3, 4'h4);
        push_exp(0, 4'h1);
        base = ack_cnt;
        prev = 0;
        REQ  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_acks(base + k + 1, 12, "rr");
            if (k == 4) REQ = '0;
            if (k > 0) begin
                n_cmp = n_cmp + 1;
                if (last_ack_cyc - prev != PERIOD) begin
                    n_err++;
                    $display("FAIL rr_spacing: ACK %0d after previous by %0d cycles, expected %0d", k, last_ack_cyc - prev, PERIOD);
                end
            end
            prev = last_ack_cyc;
        end
        tick();
        tick();
        check_drained("rr");
    endtask

    task automatic test_pulse();
        int base;
        base = ack_cnt;
        tick();
        set_data(2, 4'h5);
        REQ = 4'b0100;
        push_exp(2, 4'h5);
        tick();
        REQ = '0;
        wait_acks(base + 1, 10, "pulse");
        tick();
        check_drained("pulse");
    endtask

    task automatic test_readback();
        int base;
        base      = ack_cnt;
        force_bad = 1'b1;
        tick();
        set_data(1, 4'hF);
        REQ = 4'b0010;
        push_exp(1, 4'hF);
        tick();
        REQ = '0;
        wait_acks(base + 1, 10, "rb_bad");
        force_bad = 1'b0;
        n_cmp = n_cmp + 1;
        if (err_at_ack !== EXP_ERR) begin n_err++; $display("FAIL rb_err_at_ack: got %b, expected %b", err_at_ack, EXP_ERR); end
        tick();
        set_data(3, 4'h7);
        REQ = 4'b1000;
        push_exp(3, 4'h7);
        tick();
        REQ = '0;
        wait_acks(base + 2, 10, "rb_good");
        tick();
        n_cmp = n_cmp + 1;
        if (ERR !== EXP_ERR) begin n_err++; $display("FAIL rb_err_sticky: got %b, expected %b", ERR, EXP_ERR); end
        check_drained("rb");
    endtask

    task automatic test_reset_mid();
        int base;
        base = ack_cnt;
        tick();
        set_data(0, 4'h9);
        REQ = 4'b0001;
        push_exp(0, 4'h9);
        tick();
        REQ = '0;
        wait_acks(base + 1, 10, "mid_pre");    // LAST is now requester 0
        tick();
        set_data(3, 4'hC);
        set_data(0, 4'h6);
        REQ = 4'b1001;
        tick();                                 // LOAD cycle for requester 3
        n_cmp = n_cmp + 1;
        if (GNT !== 4'b1000) begin n_err++; $display("FAIL mid_rr_gnt: got %b, expected 1000", GNT); end
        RST_N = 1'b0;
        #1;
        n_cmp = n_cmp + 1;
        if (GNT !== '0)        begin n_err++; $display("FAIL mid_gnt: got %b, expected 0", GNT); end
        n_cmp = n_cmp + 1;
        if (REG_LOAD !== 1'b0) begin n_err++; $display("FAIL mid_load: got %b, expected 0", REG_LOAD); end
        n_cmp = n_cmp + 1;
        if (BUSY !== 1'b0)     begin n_err++; $display("FAIL mid_busy: got %b, expected 0", BUSY); end
        n_cmp = n_cmp + 1;
        if (ERR !== 1'b0)      begin n_err++; $display("FAIL mid_err: got %b, expected 0", ERR); end
        tick();
        tick();
        RST_N = 1'b1;
        push_exp(0, 4'h6);                      // requester 0 first again, no stale ACK for 3
        wait_acks(base + 2, 10, "mid_post");
        REQ = '0;
        tick();
        tick();
        check_drained("mid");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_pulse();
        test_readback();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_load_arbiter.md
# reg_load_arbiter

Round-robin arbiter and load sequencer that shares one loadable WIDTH-bit register between NREQ requesters. Each requester presents a data word and a request. The block grants one requester at a time, drives the register's data and load inputs for exactly one cycle, and returns a one-cycle acknowledge. It sits between the requesting datapaths and the register's DIN/LOAD/Q pins.

## Interface
Parameters:
- WIDTH, default 4: width of the shared register and of each requester's data word.
- NREQ, default 4: number of requesters; legal range 2..8.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  reset; asynchronous, active-low.
- REQ  in  NREQ  request; REQ[i] is requester i.
- DATA  in  NREQ*WIDTH  requester i's word is DATA[WIDTH*i +: WIDTH].
- GNT  out  NREQ  one-hot grant; high while requester i's load is in progress.
- ACK  out  NREQ  one-hot, one-cycle completion pulse.
- REG_DIN  out  WIDTH  drives the register's DIN pin.
- REG_LOAD  out  1  drives the register's LOAD pin.
- REG_Q  in  WIDTH  register's Q output; used for readback only.
- BUSY  out  1  high whenever the state is not IDLE.
- ERR  out  1  sticky readback-mismatch flag.

All outputs are registered.

## Operation
- FSM states: IDLE, LOAD, CHECK, ACK.
- IDLE, when any REQ bit is high:
  - Select winner w: the first set REQ bit searching LAST+1, LAST+2, … modulo NREQ.
  - Latch DATA word w into REG_DIN.
  - Set GNT[w].
  - Go to LOAD.
- IDLE with no request: hold; all outputs stay at their idle values.
- LOAD:
  - REG_LOAD=1 for exactly this one cycle; GNT[w] stays high.
  - Next state is CHECK when READBACK_EN is defined, otherwise ACK.
- CHECK:
  - REG_LOAD=0, GNT[w] stays high.
  - Compare REG_Q with REG_DIN. On mismatch set ERR=1; ERR clears only on reset.
  - Go to ACK.
- ACK:
  - GNT=0, ACK[w]=1 for exactly one cycle.
  - LAST<=w.
  - Go to IDLE.
- Arbitration happens only in IDLE. REQ changes in LOAD, CHECK or ACK have no effect.
- A requester that drops REQ after being granted still gets its load and its ACK, because the data was latched at grant.
- A requester that holds REQ through ACK is seen as a new request in the following IDLE cycle. Round-robin order still applies, so other pending requesters win first.
- REG_DIN holds its last loaded value between transactions.
- Reset values (asynchronous, immediate):
  - state IDLE.
  - GNT=0, ACK=0, REG_LOAD=0, REG_DIN=0, BUSY=0, ERR=0.
  - LAST=NREQ-1, so requester 0 has first priority after reset.
- Reset asserted mid-transaction aborts it. No ACK is issued. The register may or may not have been loaded, depending on whether the LOAD-cycle edge occurred first.

## Timing
- REQ is sampled at the edge ending IDLE cycle N.
- Cycle N+1: GNT and REG_LOAD high, REG_DIN valid. The register captures at the edge ending N+1.
- Without READBACK_EN:
  - ACK is high in cycle N+2.
  - IDLE in N+3.
  - Minimum of 3 cycles per transaction.
- With READBACK_EN:
  - CHECK is in N+2; REG_Q must already show the new value.
  - ACK is high in N+3.
  - IDLE in N+4.
  - Minimum of 4 cycles per transaction.
- Back-to-back requests leave exactly one IDLE cycle between transactions.
- ERR rises in the cycle after CHECK, which is the same cycle as ACK.

## Configuration
- Macro: READBACK_EN.
- Defined: the CHECK state exists and performs the REG_Q comparison; ERR is live.
- Undefined: CHECK is removed, LOAD goes directly to ACK, ERR is tied to 0, and REG_Q is unused.

## Test plan
- After reset: GNT=0, REG_LOAD=0, REG_DIN=0, ERR=0. Then REQ=0001 with DATA0=4'hA → GNT=0001 and REG_LOAD=1 one cycle later; register Q=4'hA; ACK=0001 at N+2 (N+3 with READBACK_EN).
- REQ=1111 held constant, with DATA words 1, 2, 3, 4 → ACK order 0, 1, 2, 3, 0; register Q sequence 1, 2, 3, 4, 1; exactly one IDLE cycle between transactions.
- REQ[2] pulsed for one cycle only, with DATA2=4'h5 → full transaction completes; Q=4'h5; ACK=0100.
- READBACK_EN defined, bench forces REG_Q=4'h0 while loading 4'hF → ERR=1 in the ACK cycle and stays 1 through later good loads until RST_N=0.
- RST_N asserted during the LOAD cycle → GNT, REG_LOAD and BUSY are 0 immediately; no ACK is issued; the next request goes to requester 0 first.
